// File: rtl/bus_ram.sv
// rtl/bus_ram.sv - single-port burst RAM behind a req/ack handshake with wait states
//
// Purpose: accepts a burst request in IDLE, then performs blen+1 beats. Each
// beat spends WAIT cycles in WAIT followed by one XFER cycle that asserts ack.
// The address increments per beat and wraps from DEPTH-1 to 0. A start address
// >= DEPTH is rejected with an oob pulse and no access is performed.
//
// Optional feature macro: BUS_RAM_PARITY_EN (adds a stored even-parity bit,
// the par_inj input and the perr output).
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   req     in   transaction request, sampled only in IDLE
//   we      in   1 = write burst, 0 = read burst
//   addr    in   [ADDR_W] start address
//   blen    in   [4] burst length minus one
//   wdata   in   [DATA_W] write data, sampled in each write XFER cycle
//   par_inj in   invert stored parity bit on a write beat (parity build only)
//   perr    out  parity failure, pulsed with rvalid (parity build only)
//   rdata   out  [DATA_W] registered read data
//   rvalid  out  one-cycle pulse, rdata holds a new beat
//   ack     out  high during each XFER cycle
//   busy    out  high in every state except IDLE
//   oob     out  one-cycle pulse after a request with start address >= DEPTH

module bus_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        blen,
    input  logic [DATA_W-1:0] wdata,
`ifdef BUS_RAM_PARITY_EN
    input  logic              par_inj,
    output logic              perr,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              ack,
    output logic              busy,
    output logic              oob
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [3:0]       WAIT_LAST = 4'((WAIT > 0) ? WAIT - 1 : 0);
    localparam bit               HAS_WAIT  = (WAIT > 0);

`ifdef BUS_RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [MEM_W-1:0] mem [0:DEPTH-1];
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] rd_word;

    logic [IDX_W-1:0] cur_idx;
    logic             cur_we;
    logic [3:0]       beat_cnt;
    logic [3:0]       wait_cnt;
    logic             addr_oob;
    logic             oob_nx;

    assign addr_oob = ({1'b0, addr} >= DEPTH_X);

`ifdef BUS_RAM_PARITY_EN
    // Top bit is even parity over the data; par_inj deliberately corrupts it.
    assign wr_word = {(^wdata) ^ par_inj, wdata};
`else
    assign wr_word = wdata;
`endif

    assign rd_word = mem[cur_idx];

    assign ack  = (state == S_XFER);
    assign busy = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        oob_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (addr_oob) begin
                        oob_nx = 1'b1;
                    end else begin
                        state_nx = HAS_WAIT ? S_WAIT : S_XFER;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nx = S_XFER;
                end
            end
            S_XFER: begin
                if (beat_cnt == 4'd0) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = HAS_WAIT ? S_WAIT : S_XFER;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            oob      <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            cur_idx  <= '0;
            cur_we   <= 1'b0;
            beat_cnt <= 4'd0;
            wait_cnt <= 4'd0;
`ifdef BUS_RAM_PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            oob    <= oob_nx;
            rvalid <= 1'b0;
`ifdef BUS_RAM_PARITY_EN
            perr   <= 1'b0;
`endif
            if (state == S_IDLE && req) begin
                cur_we   <= we;
                cur_idx  <= addr[IDX_W-1:0];
                beat_cnt <= blen;
            end

            wait_cnt <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;

            if (state == S_XFER) begin
                cur_idx <= (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
                if (beat_cnt != 4'd0) begin
                    beat_cnt <= beat_cnt - 4'd1;
                end
                if (!cur_we) begin
                    rdata  <= rd_word[DATA_W-1:0];
                    rvalid <= 1'b1;
`ifdef BUS_RAM_PARITY_EN
                    perr   <= ^rd_word;
`endif
                end
            end
        end
    end

    // Memory is never reset; a reset on the write edge blocks that write.
    always_ff @(posedge clk) begin
        if (!rst && state == S_XFER && cur_we) begin
            mem[cur_idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_bus_ram.sv
// tb/tb_bus_ram.sv - scoreboard testbench for bus_ram (WAIT=1 and WAIT=0 instances)

module tb_bus_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, we0, rvalid0, ack0, busy0, oob0;
    logic [15:0] addr0;
    logic [3:0]  blen0;
    logic [7:0]  wdata0, rdata0;
    logic        req1, we1, rvalid1, ack1, busy1, oob1;
    logic [15:0] addr1;
    logic [3:0]  blen1;
    logic [7:0]  wdata1, rdata1;
`ifdef BUS_RAM_PARITY_EN
    logic        par_inj0, perr0, par_inj1, perr1;
`endif

    bus_ram #(.DATA_W(8), .ADDR_W(16), .DEPTH(1024), .WAIT(1)) u0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .blen(blen0),
        .wdata(wdata0),
`ifdef BUS_RAM_PARITY_EN
        .par_inj(par_inj0), .perr(perr0),
`endif
        .rdata(rdata0), .rvalid(rvalid0), .ack(ack0), .busy(busy0), .oob(oob0)
    );

    bus_ram #(.DATA_W(8), .ADDR_W(16), .DEPTH(1024), .WAIT(0)) u1 (
        .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .blen(blen1),
        .wdata(wdata1),
`ifdef BUS_RAM_PARITY_EN
        .par_inj(par_inj1), .perr(perr1),
`endif
        .rdata(rdata1), .rvalid(rvalid1), .ack(ack1), .busy(busy1), .oob(oob1)
    );

    typedef struct {
        logic [7:0] d;
        logic       p;
        int         c;
    } sb_t;

    sb_t q0[$];
    sb_t q1[$];

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int ack_cnt0 = 0;
    int ack_cnt1 = 0;
    logic [7:0] bd [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ack0) ack_cnt0++;
        if (ack1) ack_cnt1++;
        if (rvalid0) begin
            if (q0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb0_extra_rvalid act=%h exp=none", rdata0);
            end else begin : pop0
                sb_t e;
                e = q0.pop_front();
                chk("sb0_rdata", 32'(rdata0), 32'(e.d));
                chk("sb0_rvalid_cycle", cyc, e.c + 1);
`ifdef BUS_RAM_PARITY_EN
                chk("sb0_perr", 32'(perr0), 32'(e.p));
`endif
            end
        end
        if (rvalid1) begin
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb1_extra_rvalid act=%h exp=none", rdata1);
            end else begin : pop1
                sb_t e;
                e = q1.pop_front();
                chk("sb1_rdata", 32'(rdata1), 32'(e.d));
                chk("sb1_rvalid_cycle", cyc, e.c + 1);
`ifdef BUS_RAM_PARITY_EN
                chk("sb1_perr", 32'(perr1), 32'(e.p));
`endif
            end
        end
    end

    function automatic logic get_ack(input int sel);
        return (sel == 0) ? ack0 : ack1;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [15:0] a, input logic [3:0] bl);
        if (sel == 0) begin
            req0 = r; we0 = w; addr0 = a; blen0 = bl;
        end else begin
            req1 = r; we1 = w; addr1 = a; blen1 = bl;
        end
    endtask

    task automatic set_wdata(input int sel, input logic [7:0] d, input logic p);
        if (sel == 0) wdata0 = d;
        else          wdata1 = d;
`ifdef BUS_RAM_PARITY_EN
        if (sel == 0) par_inj0 = p;
        else          par_inj1 = p;
`endif
    endtask

    task automatic push(input int sel, input logic [7:0] d, input logic p);
        sb_t e;
        e.d = d; e.p = p; e.c = cyc;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    // One burst on instance sel using bd[] as write data / expected read data.
    // req_at: beat index at which a stray req is raised (dropped two beats later).
    // rst_at: beat index whose XFER edge coincides with reset; burst ends there.
    task automatic burst(input int sel, input bit w, input logic [15:0] a,
                         input logic [3:0] bl, input bit pinj, input bit pexp,
                         input int req_at, input int rst_at);
        int lat, n, n_exp;
        lat = (sel == 0) ? 2 : 1;
        @(negedge clk);
        drive(sel, 1'b1, w, a, bl);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 16'h0, 4'h0);
        n = 1;
        chk("busy_start", 32'(get_busy(sel)), 32'd1);
        for (int k = 0; k <= int'(bl); k++) begin
            n_exp = lat * (k + 1);
            while (!get_ack(sel) && n < n_exp + 8) begin
                @(negedge clk);
                n++;
            end
            chk("ack_latency", n, n_exp);
            if (!get_ack(sel)) return;
            chk("busy_xfer", 32'(get_busy(sel)), 32'd1);
            if (w) set_wdata(sel, bd[k], pinj);
            else   push(sel, bd[k], pexp);
            if (req_at >= 0 && k == req_at)     drive(sel, 1'b1, 1'b1, 16'h0200, 4'h0);
            if (req_at >= 0 && k == req_at + 2) drive(sel, 1'b0, 1'b0, 16'h0, 4'h0);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_rdata",  32'(rdata0),  32'd0);
                chk("rst_rvalid", 32'(rvalid0), 32'd0);
                chk("rst_ack",    32'(ack0),    32'd0);
                chk("rst_busy",   32'(busy0),   32'd0);
                chk("rst_oob",    32'(oob0),    32'd0);
`ifdef BUS_RAM_PARITY_EN
                chk("rst_perr",   32'(perr0),   32'd0);
`endif
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
        chk("busy_end", 32'(get_busy(sel)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int a0, a1;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 4'h0);
        set_wdata(0, 8'h00, 1'b0);
        set_wdata(1, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rdata",  32'(rdata0),  32'd0);
        chk("reset_rvalid", 32'(rvalid0), 32'd0);
        chk("reset_ack",    32'(ack0),    32'd0);
        chk("reset_busy",   32'(busy0),   32'd0);
        chk("reset_oob",    32'(oob0),    32'd0);
        chk("reset_busy1",  32'(busy1),   32'd0);
        rst = 1'b0;

        // Single write then read.
        bd[0] = 8'hA5;
        burst(0, 1'b1, 16'h0010, 4'd0, 1'b0, 1'b0, -1, -1);
        burst(0, 1'b0, 16'h0010, 4'd0, 1'b0, 1'b0, -1, -1);

        // Wrapping burst across DEPTH-1 -> 0.
        bd[0] = 8'h11; bd[1] = 8'h22; bd[2] = 8'h33; bd[3] = 8'h44;
        burst(0, 1'b1, 16'h03FE, 4'd3, 1'b0, 1'b0, -1, -1);
        burst(0, 1'b0, 16'h03FE, 4'd3, 1'b0, 1'b0, -1, -1);
        bd[0] = 8'h33;
        burst(0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, -1, -1);

        // Out-of-bounds request.
        @(negedge clk);
        a0 = ack_cnt0;
        drive(0, 1'b1, 1'b1, 16'h0400, 4'h2);
        wdata0 = 8'hEE;
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0, 4'h0);
        chk("oob_pulse",      32'(oob0),  32'd1);
        chk("oob_busy",       32'(busy0), 32'd0);
        @(negedge clk);
        chk("oob_pulse_end",  32'(oob0),  32'd0);
        chk("oob_busy_after", 32'(busy0), 32'd0);
        repeat (4) @(negedge clk);
        chk("oob_no_ack", ack_cnt0, a0);
        bd[0] = 8'h33;
        burst(0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, -1, -1);

        // Reset on the second write beat of a 4-beat burst.
        bd[0] = 8'h01; bd[1] = 8'h02; bd[2] = 8'h03; bd[3] = 8'h04;
        burst(0, 1'b1, 16'h0020, 4'd3, 1'b0, 1'b0, -1, -1);
        chk("rdata_hold_write", 32'(rdata0), 32'h33);
        bd[0] = 8'hC0; bd[1] = 8'hC1; bd[2] = 8'hC2; bd[3] = 8'hC3;
        burst(0, 1'b1, 16'h0020, 4'd3, 1'b0, 1'b0, -1, 1);
        a0 = ack_cnt0;
        repeat (6) @(negedge clk);
        chk("rst_no_more_ack", ack_cnt0, a0);
        bd[0] = 8'hC0; bd[1] = 8'h02; bd[2] = 8'h03; bd[3] = 8'h04;
        burst(0, 1'b0, 16'h0020, 4'd3, 1'b0, 1'b0, -1, -1);

        // WAIT=0 instance: 16-beat back-to-back bursts, stray req mid-read.
        for (int i = 0; i < 16; i++) bd[i] = 8'(i * 7 + 3);
        burst(1, 1'b1, 16'h0100, 4'd15, 1'b0, 1'b0, -1, -1);
        burst(1, 1'b0, 16'h0100, 4'd15, 1'b0, 1'b0, 5, -1);
        a1 = ack_cnt1;
        repeat (6) @(negedge clk);
        chk("w0_no_extra_ack", ack_cnt1, a1);
        chk("w0_idle_after",   32'(busy1), 32'd0);

`ifdef BUS_RAM_PARITY_EN
        bd[0] = 8'h5A;
        burst(0, 1'b1, 16'h0005, 4'd0, 1'b1, 1'b0, -1, -1);
        burst(0, 1'b0, 16'h0005, 4'd0, 1'b0, 1'b1, -1, -1);
        burst(0, 1'b1, 16'h0005, 4'd0, 1'b0, 1'b0, -1, -1);
        burst(0, 1'b0, 16'h0005, 4'd0, 1'b0, 1'b0, -1, -1);
`endif

        repeat (4) @(negedge clk);
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
